lvds_rd_arbiter: RTL and testbench
==================================

LVDS_RD_ARBITER -- requirements
Module: lvds_rd_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, meaning the buffer read-address width (512 words).
REQ-002 SHALL have parameter DATA_W, default 32, meaning the buffer read-data width.
REQ-003 SHALL have one clock and a synchronous, active-high reset; no other clock or reset exists.
REQ-004 SHALL have port CLK  in  1  system clock; all logic on posedge.
REQ-005 SHALL have port RST  in  1  synchronous active-high reset.
REQ-006 SHALL have ports REQn_VALID  in  1  burst request from requester n (n = 0, 1).
REQ-007 SHALL have ports REQn_ADDR  in  ADDR_W  burst start word address.
REQ-008 SHALL have ports REQn_LEN  in  4  burst length minus one (1..16 words).
REQ-009 SHALL have ports REQn_READY  out  1  one-cycle accept pulse.
REQ-010 SHALL have ports REQn_RVALID  out  1  read-data strobe.
REQ-011 SHALL have ports REQn_RDATA  out  DATA_W  read data.
REQ-012 SHALL have ports REQn_RLAST  out  1  marks the final word of the burst.
REQ-013 SHALL have port BUF_RADDR  out  ADDR_W  address to the shared buffer read port.
REQ-014 SHALL have port BUF_RD  in  DATA_W  buffer read data, valid one cycle after BUF_RADDR.
REQ-015 SHALL have port LVDS_STATE  in  8  receiver status (02h = frame complete); present only under the macro in REQ-033.

Function
REQ-016 SHALL implement a three-state FSM: IDLE, BURST and DRAIN.
REQ-017 In IDLE, SHALL grant exactly one VALID requester per cycle: pulse its READY and latch its ADDR and LEN, then go to BURST.
REQ-018 For simultaneous requests, SHALL grant the requester selected by the round-robin pointer; after reset the pointer favours requester 0.
REQ-019 After each completed burst, SHALL point the round-robin pointer at the requester that was not granted.
REQ-020 In BURST, SHALL drive BUF_RADDR = latched ADDR + beat count, modulo 2^ADDR_W, for LEN+1 consecutive cycles; address 511 wraps to 0.
REQ-021 SHALL assert the granted RVALID with RDATA = BUF_RD exactly one cycle after each BUF_RADDR beat.
REQ-022 SHALL assert RLAST together with the final RVALID.
REQ-023 SHALL spend one cycle in DRAIN after the last address, then return to IDLE.
REQ-024 Timing: READY at cycle T; first address at T+1; first RVALID at T+2; RLAST at T+LEN+2; next grant no earlier than T+LEN+3.
REQ-025 SHALL provide no read-data backpressure; requesters shall sample on every RVALID.
REQ-026 SHALL never assert the RVALID or READY of the non-granted requester.
REQ-027 SHALL ignore VALID during BURST and DRAIN; requests are level-held until READY.
REQ-028 SHALL hold BUF_RADDR at its last value when idle.

Reset
REQ-029 On RST, SHALL go to IDLE, clear the round-robin pointer to 0, and drive every output to 0 in the next cycle.
REQ-030 On RST mid-burst, SHALL abort the burst, with no further RVALID or RLAST from the aborted burst.
REQ-031 While RST is high, SHALL not grant any request.
REQ-032 When RST deasserts, SHALL allow a grant in the first cycle.

Configuration
REQ-033 With LVDS_ARB_FRAME_GATE_EN defined, SHALL include LVDS_STATE and grant only while LVDS_STATE == 8'h02; a burst already in progress completes even if LVDS_STATE changes.
REQ-034 Without LVDS_ARB_FRAME_GATE_EN, SHALL omit the LVDS_STATE port and leave grants ungated.

Structure
REQ-035 SHALL place the FSM state encoding, ADDR_W/DATA_W defaults and the FRAME_DONE constant (8'h02) in shared package lvds_arb_pkg.
REQ-036 SHALL implement the two-way round-robin selection in sub-module lvds_rr_pick (inputs: two requests and the pointer; output: one-hot grant).

Verification
REQ-037 Single request: REQ0 ADDR=10h, LEN=3 -> READY0 at T; BUF_RADDR 10h..13h at T+1..T+4; four RVALID0 beats T+2..T+5 carrying the buffer words; RLAST0 at T+5.
REQ-038 Contention: both VALID at the same cycle after reset -> REQ0 served first, then REQ1; with both held, grants alternate 0,1,0,1.
REQ-039 Wrap: REQ1 ADDR=1FEh, LEN=3 -> BUF_RADDR 1FEh, 1FFh, 000h, 001h.
REQ-040 Abort: RST at the second beat of a 16-beat burst -> next cycle all outputs 0, no RLAST, pointer = 0.
REQ-041 Gate (macro on): VALID0 with LVDS_STATE=01h -> no READY; LVDS_STATE goes to 02h -> READY0 in the same cycle.
REQ-042 Isolation: during a REQ0 burst, REQ1_RVALID and REQ1_READY stay 0 on every cycle.

Source files
------------

// File: rtl/lvds_arb_pkg.sv
// Shared definitions for the LVDS read-buffer arbiter: FSM state encoding,
// default bus widths and the receiver "frame complete" status code.
package lvds_arb_pkg;

    localparam int ADDR_W_DEFAULT = 9;
    localparam int DATA_W_DEFAULT = 32;

    // LVDS receiver status value meaning a full frame sits in the buffer.
    localparam logic [7:0] FRAME_DONE = 8'h02;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DRAIN = 2'd2
    } arb_state_t;

endpackage

// File: rtl/lvds_rd_arbiter_if.sv
// Bundle of the requester handshakes and the shared buffer read port.
//
// Handshake: a requester raises reqN_valid with addr/len stable and holds it
// until reqN_ready pulses for one cycle; the burst is accepted on that cycle.
// Read data has no backpressure: every cycle reqN_rvalid is high the
// requester must take reqN_rdata; reqN_rlast marks the final word.
interface lvds_rd_arbiter_if
    import lvds_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
);
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_addr;
    logic [3:0]        req0_len;
    logic              req0_ready;
    logic              req0_rvalid;
    logic [DATA_W-1:0] req0_rdata;
    logic              req0_rlast;

    logic              req1_valid;
    logic [ADDR_W-1:0] req1_addr;
    logic [3:0]        req1_len;
    logic              req1_ready;
    logic              req1_rvalid;
    logic [DATA_W-1:0] req1_rdata;
    logic              req1_rlast;

    logic [ADDR_W-1:0] buf_raddr;
    logic [DATA_W-1:0] buf_rd;

    // Requester + buffer side.
    modport master (
        output req0_valid, req0_addr, req0_len,
        output req1_valid, req1_addr, req1_len,
        output buf_rd,
        input  req0_ready, req0_rvalid, req0_rdata, req0_rlast,
        input  req1_ready, req1_rvalid, req1_rdata, req1_rlast,
        input  buf_raddr
    );

    // Arbiter side.
    modport slave (
        input  req0_valid, req0_addr, req0_len,
        input  req1_valid, req1_addr, req1_len,
        input  buf_rd,
        output req0_ready, req0_rvalid, req0_rdata, req0_rlast,
        output req1_ready, req1_rvalid, req1_rdata, req1_rlast,
        output buf_raddr
    );
endinterface

// File: rtl/lvds_rr_pick.sv
// Two-way round-robin picker: the requester named by ptr wins a tie,
// otherwise whichever single requester is active wins. One-hot output.
module lvds_rr_pick (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);

    // Priority order flips with the pointer.
    always_comb begin
        gnt = 2'b00;
        if (ptr == 1'b0) begin
            if (req[0])      gnt = 2'b01;
            else if (req[1]) gnt = 2'b10;
        end else begin
            if (req[1])      gnt = 2'b10;
            else if (req[0]) gnt = 2'b01;
        end
    end

endmodule

// File: rtl/lvds_rd_arbiter.sv
// Arbitrates two burst readers onto the single read port of the LVDS
// receive buffer. Optional frame gating: define LVDS_ARB_FRAME_GATE_EN to add
// the LVDS_STATE input and only grant while it reports FRAME_DONE.
// READY is combinational from VALID so a grant lands in the request cycle;
// RDATA is a masked pass-through of BUF_RD, which already lags BUF_RADDR by
// one cycle and therefore lines up with the registered RVALID.
module lvds_rd_arbiter
    import lvds_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              CLK,
    input  logic              RST,

    input  logic              REQ0_VALID,
    input  logic [ADDR_W-1:0] REQ0_ADDR,
    input  logic [3:0]        REQ0_LEN,
    output logic              REQ0_READY,
    output logic              REQ0_RVALID,
    output logic [DATA_W-1:0] REQ0_RDATA,
    output logic              REQ0_RLAST,

    input  logic              REQ1_VALID,
    input  logic [ADDR_W-1:0] REQ1_ADDR,
    input  logic [3:0]        REQ1_LEN,
    output logic              REQ1_READY,
    output logic              REQ1_RVALID,
    output logic [DATA_W-1:0] REQ1_RDATA,
    output logic              REQ1_RLAST,

    output logic [ADDR_W-1:0] BUF_RADDR,
    input  logic [DATA_W-1:0] BUF_RD,
`ifdef LVDS_ARB_FRAME_GATE_EN
    input  logic [7:0]        LVDS_STATE,
`endif
    output arb_state_t        DBG_STATE
);

    arb_state_t        state_q, state_d;
    logic              ptr_q, ptr_d;       // round-robin: requester favoured on a tie
    logic              sel_q, sel_d;       // requester owning the current burst
    logic [3:0]        len_q, len_d;
    logic [3:0]        beat_q, beat_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic              rvalid_q, rvalid_d;
    logic              rlast_q, rlast_d;

    logic              grant_en;
    logic [1:0]        pick;
    logic [1:0]        grant_vec;

    lvds_rr_pick u_pick (
        .req (({REQ1_VALID, REQ0_VALID})),
        .ptr (ptr_q),
        .gnt (pick)
    );

    // Grant qualification: never during reset, optionally only on a full frame.
    always_comb begin
`ifdef LVDS_ARB_FRAME_GATE_EN
        grant_en = !RST && (LVDS_STATE == FRAME_DONE);
`else
        grant_en = !RST;
`endif
        grant_vec = (state_q == ST_IDLE && grant_en) ? pick : 2'b00;
    end

    // Next-state logic for the IDLE -> BURST -> DRAIN sequence.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        sel_d    = sel_q;
        len_d    = len_q;
        beat_d   = beat_q;
        raddr_d  = raddr_q;
        rvalid_d = 1'b0;
        rlast_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_vec != 2'b00) begin
                    sel_d   = grant_vec[1];
                    raddr_d = grant_vec[1] ? REQ1_ADDR : REQ0_ADDR;
                    len_d   = grant_vec[1] ? REQ1_LEN : REQ0_LEN;
                    beat_d  = 4'd0;
                    state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                // Each address cycle produces a data beat on the next cycle.
                rvalid_d = 1'b1;
                rlast_d  = (beat_q == len_q);
                if (beat_q == len_q) begin
                    state_d = ST_DRAIN;
                end else begin
                    beat_d  = beat_q + 4'd1;
                    raddr_d = raddr_q + ADDR_W'(1);
                end
            end
            ST_DRAIN: begin
                // Burst done: hand priority to the other requester.
                ptr_d   = ~sel_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset aborts any burst and clears every output.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            ptr_q    <= 1'b0;
            sel_q    <= 1'b0;
            len_q    <= 4'd0;
            beat_q   <= 4'd0;
            raddr_q  <= '0;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            sel_q    <= sel_d;
            len_q    <= len_d;
            beat_q   <= beat_d;
            raddr_q  <= raddr_d;
            rvalid_q <= rvalid_d;
            rlast_q  <= rlast_d;
        end
    end

    // Route the beat to the owning requester only; the other side stays 0.
    always_comb begin
        REQ0_READY  = grant_vec[0];
        REQ1_READY  = grant_vec[1];
        REQ0_RVALID = rvalid_q & ~sel_q;
        REQ1_RVALID = rvalid_q & sel_q;
        REQ0_RLAST  = rlast_q & ~sel_q;
        REQ1_RLAST  = rlast_q & sel_q;
        REQ0_RDATA  = REQ0_RVALID ? BUF_RD : '0;
        REQ1_RDATA  = REQ1_RVALID ? BUF_RD : '0;
        BUF_RADDR   = raddr_q;
        DBG_STATE   = state_q;
    end

endmodule

// File: tb/tb_lvds_rd_arbiter.sv
// Directed bench for lvds_rd_arbiter: reset, single burst, abort, round-robin
// contention, address wrap and (when LVDS_ARB_FRAME_GATE_EN is defined) frame gating.
module tb_lvds_rd_arbiter;
  import lvds_arb_pkg::*;

  localparam int AW = 9;
  localparam int DW = 32;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  arb_state_t dbg_state;
`ifdef LVDS_ARB_FRAME_GATE_EN
  logic [7:0] lvds_state = FRAME_DONE;
`endif

  int n_checks = 0;
  int n_fail = 0;

  lvds_rd_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_if ();

  lvds_rd_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK         (clk),
    .RST         (rst),
    .REQ0_VALID  (bus_if.req0_valid),
    .REQ0_ADDR   (bus_if.req0_addr),
    .REQ0_LEN    (bus_if.req0_len),
    .REQ0_READY  (bus_if.req0_ready),
    .REQ0_RVALID (bus_if.req0_rvalid),
    .REQ0_RDATA  (bus_if.req0_rdata),
    .REQ0_RLAST  (bus_if.req0_rlast),
    .REQ1_VALID  (bus_if.req1_valid),
    .REQ1_ADDR   (bus_if.req1_addr),
    .REQ1_LEN    (bus_if.req1_len),
    .REQ1_READY  (bus_if.req1_ready),
    .REQ1_RVALID (bus_if.req1_rvalid),
    .REQ1_RDATA  (bus_if.req1_rdata),
    .REQ1_RLAST  (bus_if.req1_rlast),
    .BUF_RADDR   (bus_if.buf_raddr),
    .BUF_RD      (bus_if.buf_rd),
`ifdef LVDS_ARB_FRAME_GATE_EN
    .LVDS_STATE  (lvds_state),
`endif
    .DBG_STATE   (dbg_state)
  );

  // buffer model: content is a function of the address, one-cycle read latency
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {16'hC0DE, 7'h00, a};
  endfunction

  always @(posedge clk) bus_if.buf_rd <= mem_word(bus_if.buf_raddr);

  task automatic test_reset();
    rst = 1'b1;
    bus_if.req0_valid = 1'b0;
    bus_if.req1_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if ({bus_if.req0_ready, bus_if.req0_rvalid, bus_if.req0_rlast,
         bus_if.req1_ready, bus_if.req1_rvalid, bus_if.req1_rlast} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b expected 000000", {bus_if.req0_ready, bus_if.req0_rvalid,
               bus_if.req0_rlast, bus_if.req1_ready, bus_if.req1_rvalid, bus_if.req1_rlast});
    end
    n_checks++;
    if ({bus_if.req0_rdata, bus_if.req1_rdata} !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_rdata: got %h expected 0", {bus_if.req0_rdata, bus_if.req1_rdata});
    end
    n_checks++;
    if (bus_if.buf_raddr !== 9'h000) begin
      n_fail++;
      $display("FAIL reset_raddr: got %h expected 000", bus_if.buf_raddr);
    end
    n_checks++;
    if (dbg_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE);
    end
    // requests while reset is held must not be granted
    bus_if.req0_valid = 1'b1;
    bus_if.req1_valid = 1'b1;
    #1;
    n_checks++;
    if ({bus_if.req1_ready, bus_if.req0_ready} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_no_grant: got %b expected 00", {bus_if.req1_ready, bus_if.req0_ready});
    end
    // first cycle out of reset grants immediately, requester 0 favoured
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if ({bus_if.req1_ready, bus_if.req0_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_first_grant: got %b expected 01", {bus_if.req1_ready, bus_if.req0_ready});
    end
    bus_if.req0_valid = 1'b0;
    bus_if.req1_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [AW-1:0] addr;
    logic [AW-1:0] exp_a;
    logic [DW-1:0] exp_d;
    logic          exp_v;
    logic          exp_l;
    int            len;
    addr = 9'h010;
    len = 3;
    @(negedge clk);
    bus_if.req0_addr = addr;
    bus_if.req0_len = 4'(len);
    bus_if.req0_valid = 1'b1;
    #1;
    n_checks++;
    if ({bus_if.req1_ready, bus_if.req0_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL single_ready: got %b expected 01", {bus_if.req1_ready, bus_if.req0_ready});
    end
    for (int c = 1; c <= len + 3; c++) begin
      @(negedge clk);
      if (c == 1) bus_if.req0_valid = 1'b0;
      #1;
      exp_a = AW'(addr + ((c <= len + 1) ? c - 1 : len));
      exp_v = (c >= 2 && c <= len + 2);
      exp_l = (c == len + 2);
      exp_d = exp_v ? mem_word(AW'(addr + c - 2)) : '0;
      n_checks++;
      if (bus_if.buf_raddr !== exp_a) begin
        n_fail++;
        $display("FAIL single_raddr c=%0d: got %h expected %h", c, bus_if.buf_raddr, exp_a);
      end
      n_checks++;
      if ({bus_if.req0_rvalid, bus_if.req0_rlast} !== {exp_v, exp_l}) begin
        n_fail++;
        $display("FAIL single_rvalid_rlast c=%0d: got %b expected %b", c,
                 {bus_if.req0_rvalid, bus_if.req0_rlast}, {exp_v, exp_l});
      end
      n_checks++;
      if (bus_if.req0_rdata !== exp_d) begin
        n_fail++;
        $display("FAIL single_rdata c=%0d: got %h expected %h", c, bus_if.req0_rdata, exp_d);
      end
      n_checks++;
      if ({bus_if.req0_ready, bus_if.req1_ready, bus_if.req1_rvalid, bus_if.req1_rlast} !== 4'b0) begin
        n_fail++;
        $display("FAIL single_isolation c=%0d: got %b expected 0000", c, {bus_if.req0_ready,
                 bus_if.req1_ready, bus_if.req1_rvalid, bus_if.req1_rlast});
      end
    end
  endtask

  task automatic test_abort();
    @(negedge clk);
    bus_if.req0_addr = 9'h020;
    bus_if.req0_len = 4'hF;
    bus_if.req0_valid = 1'b1;
    #1;
    n_checks++;
    if (bus_if.req0_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_ready: got %b expected 1", bus_if.req0_ready);
    end
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 1) bus_if.req0_valid = 1'b0;
    end
    #1;
    n_checks++;
    if (bus_if.req0_rvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_second_beat: got %b expected 1", bus_if.req0_rvalid);
    end
    rst = 1'b1;
    @(negedge clk);
    #1;
    n_checks++;
    if ({bus_if.req0_rvalid, bus_if.req0_rlast, bus_if.req1_rvalid, bus_if.req1_rlast} !== 4'b0) begin
      n_fail++;
      $display("FAIL abort_strobes: got %b expected 0000", {bus_if.req0_rvalid, bus_if.req0_rlast,
               bus_if.req1_rvalid, bus_if.req1_rlast});
    end
    n_checks++;
    if ({bus_if.buf_raddr, bus_if.req0_rdata} !== {9'h000, 32'h0}) begin
      n_fail++;
      $display("FAIL abort_bus: got raddr %h rdata %h expected 000/0", bus_if.buf_raddr, bus_if.req0_rdata);
    end
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if ({bus_if.req0_rvalid, bus_if.req0_rlast} !== 2'b00) begin
        n_fail++;
        $display("FAIL abort_no_tail c=%0d: got %b expected 00", c, {bus_if.req0_rvalid, bus_if.req0_rlast});
      end
    end
    // pointer was 1 before the abort; reset must have returned it to 0
    bus_if.req0_valid = 1'b1;
    bus_if.req1_valid = 1'b1;
    #1;
    n_checks++;
    if ({bus_if.req1_ready, bus_if.req0_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL abort_pointer: got %b expected 01", {bus_if.req1_ready, bus_if.req0_ready});
    end
    bus_if.req0_valid = 1'b0;
    bus_if.req1_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_contention();
    logic [1:0] exp_r;
    logic [1:0] exp_v;
    rst = 1'b1;
    @(negedge clk);
    bus_if.req0_addr = 9'h040;
    bus_if.req0_len = 4'd1;
    bus_if.req1_addr = 9'h080;
    bus_if.req1_len = 4'd1;
    bus_if.req0_valid = 1'b1;
    bus_if.req1_valid = 1'b1;
    rst = 1'b0;
    // two-beat bursts: grants every 4 cycles, alternating 0,1,0,1
    for (int c = 0; c < 16; c++) begin
      if (c != 0) @(negedge clk);
      #1;
      exp_r = 2'b00;
      exp_v = 2'b00;
      if (c % 4 == 0) exp_r = ((c / 4) % 2 == 0) ? 2'b01 : 2'b10;
      if (c % 4 == 2 || c % 4 == 3) exp_v = ((c / 4) % 2 == 0) ? 2'b01 : 2'b10;
      n_checks++;
      if ({bus_if.req1_ready, bus_if.req0_ready} !== exp_r) begin
        n_fail++;
        $display("FAIL contention_ready c=%0d: got %b expected %b", c,
                 {bus_if.req1_ready, bus_if.req0_ready}, exp_r);
      end
      n_checks++;
      if ({bus_if.req1_rvalid, bus_if.req0_rvalid} !== exp_v) begin
        n_fail++;
        $display("FAIL contention_rvalid c=%0d: got %b expected %b", c,
                 {bus_if.req1_rvalid, bus_if.req0_rvalid}, exp_v);
      end
      if (c == 15) begin
        bus_if.req0_valid = 1'b0;
        bus_if.req1_valid = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    logic [AW-1:0] addr;
    logic [AW-1:0] exp_a;
    logic [DW-1:0] exp_d;
    logic          exp_v;
    logic          exp_l;
    int            len;
    addr = 9'h1FE;
    len = 3;
    @(negedge clk);
    bus_if.req1_addr = addr;
    bus_if.req1_len = 4'(len);
    bus_if.req1_valid = 1'b1;
    #1;
    n_checks++;
    if ({bus_if.req1_ready, bus_if.req0_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL wrap_ready: got %b expected 10", {bus_if.req1_ready, bus_if.req0_ready});
    end
    for (int c = 1; c <= len + 3; c++) begin
      @(negedge clk);
      if (c == 1) bus_if.req1_valid = 1'b0;
      #1;
      exp_a = AW'(addr + ((c <= len + 1) ? c - 1 : len));
      exp_v = (c >= 2 && c <= len + 2);
      exp_l = (c == len + 2);
      exp_d = exp_v ? mem_word(AW'(addr + c - 2)) : '0;
      n_checks++;
      if (bus_if.buf_raddr !== exp_a) begin
        n_fail++;
        $display("FAIL wrap_raddr c=%0d: got %h expected %h", c, bus_if.buf_raddr, exp_a);
      end
      n_checks++;
      if ({bus_if.req1_rvalid, bus_if.req1_rlast} !== {exp_v, exp_l}) begin
        n_fail++;
        $display("FAIL wrap_rvalid_rlast c=%0d: got %b expected %b", c,
                 {bus_if.req1_rvalid, bus_if.req1_rlast}, {exp_v, exp_l});
      end
      n_checks++;
      if (bus_if.req1_rdata !== exp_d) begin
        n_fail++;
        $display("FAIL wrap_rdata c=%0d: got %h expected %h", c, bus_if.req1_rdata, exp_d);
      end
      n_checks++;
      if ({bus_if.req1_ready, bus_if.req0_ready, bus_if.req0_rvalid, bus_if.req0_rlast} !== 4'b0) begin
        n_fail++;
        $display("FAIL wrap_isolation c=%0d: got %b expected 0000", c, {bus_if.req1_ready,
                 bus_if.req0_ready, bus_if.req0_rvalid, bus_if.req0_rlast});
      end
    end
  endtask

`ifdef LVDS_ARB_FRAME_GATE_EN
  task automatic test_gate();
    @(negedge clk);
    lvds_state = 8'h01;
    bus_if.req0_addr = 9'h005;
    bus_if.req0_len = 4'd0;
    bus_if.req0_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (c != 0) @(negedge clk);
      #1;
      n_checks++;
      if (bus_if.req0_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL gate_blocked c=%0d: got %b expected 0", c, bus_if.req0_ready);
      end
    end
    @(negedge clk);
    lvds_state = FRAME_DONE;
    #1;
    n_checks++;
    if (bus_if.req0_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL gate_open: got %b expected 1", bus_if.req0_ready);
    end
    @(negedge clk);
    bus_if.req0_valid = 1'b0;
    lvds_state = 8'h01;
    @(negedge clk);
    #1;
    // single-beat burst still completes with the gate closed again
    n_checks++;
    if ({bus_if.req0_rvalid, bus_if.req0_rlast} !== 2'b11) begin
      n_fail++;
      $display("FAIL gate_burst_completes: got %b expected 11", {bus_if.req0_rvalid, bus_if.req0_rlast});
    end
    lvds_state = FRAME_DONE;
    repeat (2) @(negedge clk);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus_if.req0_valid = 1'b0;
    bus_if.req0_addr = '0;
    bus_if.req0_len = '0;
    bus_if.req1_valid = 1'b0;
    bus_if.req1_addr = '0;
    bus_if.req1_len = '0;
    test_reset();
    test_single();
    test_abort();
    test_contention();
    test_wrap();
`ifdef LVDS_ARB_FRAME_GATE_EN
    test_gate();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
